// File: rtl/mem_pkg.sv
// Shared encodings and request bundle for the MEM-stage data memory access unit.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RD   = 2'b01;
  localparam logic [1:0] ST_WR   = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam int unsigned ADDR_LIMIT_DEF = 128;

  typedef struct packed {
    logic        load;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane extraction with sign/zero extension for loads,
// and lane merge into the old word for sub-word stores.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic        signed_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rdata_i[{addr_i, 3'b000} +: 8];
  assign rhalf = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    load_o = rdata_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{signed_i & rbyte[7]}}, rbyte};
      SZ_HALF: load_o = {{16{signed_i & rhalf[15]}}, rhalf};
      default: load_o = rdata_i;
    endcase
  end

  always_comb begin
    merge_o = rdata_i;
    case (size_i)
      SZ_BYTE: merge_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: merge_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: validates one request, drives the
// word-wide data memory, and performs read-modify-write for sub-word stores.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEF,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_load_i,
  input  logic              req_store_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              stall_o,
  output logic              load_valid_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              err_o,
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  logic [1:0]  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mdata_q, mdata_d;
  logic [31:0] ldata_q, ldata_d;
  logic        err_q, err_d;
  logic [31:0] ext_data, merged;
  logic [32:0] end_addr;
  logic        req_bad;

  // One past the last byte touched; 33 bits so high addresses cannot wrap.
  assign end_addr = {1'b0, req_addr_i}
                  + {30'd0, size_bytes(req_size_i)};

  assign req_bad = (req_load_i == req_store_i)
                 | (req_size_i == 2'b11)
                 | ((req_size_i == SZ_HALF) & req_addr_i[0])
                 | ((req_size_i == SZ_WORD) & (req_addr_i[1:0] != 2'b00))
                 | (end_addr > 33'(ADDR_LIMIT));

  mem_lane_align u_align (
    .size_i   (req_q.size),
    .addr_i   (req_q.addr[1:0]),
    .signed_i (req_q.sgn),
    .rdata_i  (mem_data_i),
    .wdata_i  (req_q.wdata),
    .load_o   (ext_data),
    .merge_o  (merged)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    ldata_d = ldata_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            req_d   = '{load:  req_load_i,
                        size:  req_size_i,
                        sgn:   req_signed_i,
                        addr:  req_addr_i,
                        wdata: req_wdata_i};
            maddr_d = {req_addr_i[31:2], 2'b00};
            if (!req_load_i && req_size_i == SZ_WORD) begin
              mdata_d = req_wdata_i;
              state_d = ST_WR;
            end else begin
              state_d = ST_RD;
            end
          end
        end
      end
      ST_RD: begin
        if (req_q.load) begin
          ldata_d = ext_data;
          state_d = ST_DONE;
        end else begin
          mdata_d = merged;
          state_d = ST_WR;
        end
      end
      ST_WR:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      ldata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
    end
  end

  assign stall_o      = (state_q != ST_IDLE);
  assign mem_read_o   = (state_q == ST_RD);
  assign mem_write_o  = (state_q == ST_WR);
  assign load_valid_o = (state_q == ST_DONE);
  assign mem_addr_o   = maddr_q;
  assign mem_data_o   = mdata_q;
  assign load_data_o  = ldata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus pushes expected memory
// writes, load results and error pulses; a negedge monitor pops and compares.
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } wr_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] cyc;
  } ld_exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_load_i, req_store_i, req_signed_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        stall_o, load_valid_o, err_o, mem_read_o, mem_write_o;
  logic [31:0] load_data_o, mem_addr_o, mem_data_o, mem_data_i;

  logic [31:0] mem [0:31];
  logic [31:0] cyc = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  wr_exp_t     wq[$];
  ld_exp_t     lq[$];
  logic [31:0] eq[$];
  wr_exp_t     mw;
  ld_exp_t     ml;
  logic [31:0] me;

  mem_access_unit dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_load_i   (req_load_i),
    .req_store_i  (req_store_i),
    .req_size_i   (req_size_i),
    .req_signed_i (req_signed_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .stall_o      (stall_o),
    .load_valid_o (load_valid_o),
    .load_data_o  (load_data_o),
    .err_o        (err_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_data_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_data_i = (mem_addr_o < 32'd128) ? mem[mem_addr_o[6:2]] : 32'h0;

  always @(posedge clk)
    if (mem_write_o && mem_addr_o < 32'd128)
      mem[mem_addr_o[6:2]] <= mem_data_o;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every DUT event must match the head of its queue.
  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      if (stall_o)
        chk("rd/wr exclusive", {31'd0, mem_read_o & mem_write_o}, 32'd0);
      if (mem_write_o) begin
        chk("write expected", {31'd0, wq.size() != 0}, 32'd1);
        if (wq.size() != 0) begin
          mw = wq.pop_front();
          chk("write addr", mem_addr_o, mw.addr);
          chk("write data", mem_data_o, mw.data);
          chk("write cycle", cyc, mw.cyc);
        end
      end
      if (load_valid_o) begin
        chk("load expected", {31'd0, lq.size() != 0}, 32'd1);
        if (lq.size() != 0) begin
          ml = lq.pop_front();
          chk("load data", load_data_o, ml.data);
          chk("load cycle", cyc, ml.cyc);
        end
      end
      if (err_o) begin
        chk("err expected", {31'd0, eq.size() != 0}, 32'd1);
        if (eq.size() != 0) begin
          me = eq.pop_front();
          chk("err cycle", cyc, me);
        end
      end
    end
  end

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd);
    req_load_i   = ld;
    req_store_i  = st;
    req_size_i   = sz;
    req_signed_i = sg;
    req_addr_i   = a;
    req_wdata_i  = wd;
    req_valid_i  = 1'b1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] acc);
    @(negedge clk);
    for (int i = 0; i < 20 && stall_o; i++) @(negedge clk);
    drive(ld, st, sz, sg, a, wd);
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(output int busy, output logic rd1,
                           output logic en1);
    busy = 0;
    @(negedge clk);
    rd1 = mem_read_o;
    en1 = mem_read_o | mem_write_o;
    while (stall_o && busy < 10) begin
      busy++;
      @(negedge clk);
    end
  endtask

  // kind: 0 load, 1 word store, 2 sub-word store, 3 error
  task automatic run(input string nm, input logic ld, input logic st,
                     input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int kind, input logic [31:0] exp,
                     input int exp_busy);
    logic [31:0] acc;
    int          busy;
    logic        rd1, en1;
    issue(ld, st, sz, sg, a, wd, acc);
    case (kind)
      // request cycle, RD, then DONE carries load_valid_o
      0: lq.push_back('{data: exp, cyc: acc + 1});
      1: wq.push_back('{addr: {a[31:2], 2'b00}, data: exp, cyc: acc});
      2: wq.push_back('{addr: {a[31:2], 2'b00}, data: exp, cyc: acc + 1});
      default: eq.push_back(acc);
    endcase
    wait_idle(busy, rd1, en1);
    chk({nm, " busy"}, busy, exp_busy);
    if (kind == 3) chk({nm, " no mem enable"}, {31'd0, en1}, 32'd0);
    else chk({nm, " first cycle read"}, {31'd0, rd1},
             (kind == 1) ? 32'd0 : 32'd1);
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, " stall"}, {31'd0, stall_o}, 32'd0);
    chk({nm, " load_valid"}, {31'd0, load_valid_o}, 32'd0);
    chk({nm, " load_data"}, load_data_o, 32'd0);
    chk({nm, " err"}, {31'd0, err_o}, 32'd0);
    chk({nm, " mem_addr"}, mem_addr_o, 32'd0);
    chk({nm, " mem_data"}, mem_data_o, 32'd0);
    chk({nm, " mem_read"}, {31'd0, mem_read_o}, 32'd0);
    chk({nm, " mem_write"}, {31'd0, mem_write_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] acc1, acc2;
    int          busy;
    logic        rd1, en1;

    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[8]  = 32'h1122_3344;
    mem[12] = 32'h80FF_7F01;
    mem[31] = 32'h5A00_0000;

    rst_i = 1'b0;
    req_valid_i = 1'b0;
    drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst_i = 1'b1;

    run("word store", 0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF,
        1, 32'hDEADBEEF, 1);
    run("word load", 1, 0, SZ_WORD, 0, 32'h10, 32'h0,
        0, 32'hDEADBEEF, 2);
    run("byte rmw", 0, 1, SZ_BYTE, 0, 32'h22, 32'hFFFF_FFAA,
        2, 32'h11AA_3344, 2);
    run("rmw readback", 1, 0, SZ_WORD, 0, 32'h20, 32'h0,
        0, 32'h11AA_3344, 2);
    run("lb @32", 1, 0, SZ_BYTE, 1, 32'h32, 32'h0, 0, 32'hFFFF_FFFF, 2);
    run("lbu @33", 1, 0, SZ_BYTE, 0, 32'h33, 32'h0, 0, 32'h0000_0080, 2);
    run("lh @32", 1, 0, SZ_HALF, 1, 32'h32, 32'h0, 0, 32'hFFFF_80FF, 2);
    run("lhu @30", 1, 0, SZ_HALF, 0, 32'h30, 32'h0, 0, 32'h0000_7F01, 2);
    run("lbu @7F", 1, 0, SZ_BYTE, 0, 32'h7F, 32'h0, 0, 32'h0000_005A, 2);

    run("err lh @05", 1, 0, SZ_HALF, 1, 32'h05, 32'h0, 3, 32'h0, 0);
    run("err sw @7E", 0, 1, SZ_WORD, 0, 32'h7E, 32'h1, 3, 32'h0, 0);
    run("err lw @80", 1, 0, SZ_WORD, 0, 32'h80, 32'h0, 3, 32'h0, 0);
    run("err ld+st", 1, 1, SZ_WORD, 0, 32'h10, 32'h0, 3, 32'h0, 0);
    run("err size 11", 1, 0, 2'b11, 0, 32'h10, 32'h0, 3, 32'h0, 0);

    // Abort a sub-word store during its RD cycle.
    issue(0, 1, SZ_BYTE, 0, 32'h24, 32'h0000_00FF, acc1);
    @(negedge clk);
    chk("abort in RD", {31'd0, mem_read_o}, 32'd1);
    #1;
    rst_i = 1'b0;
    #1;
    chk_outs_zero("mid-op reset");
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("aborted word untouched", mem[9], 32'h0);
    run("post-reset sb", 0, 1, SZ_BYTE, 0, 32'h21, 32'h0000_0077,
        2, 32'h11AA_7744, 2);
    run("post-reset lw @24", 1, 0, SZ_WORD, 0, 32'h24, 32'h0,
        0, 32'h0, 2);

    // Back-to-back: second request held through the store.
    @(negedge clk);
    drive(0, 1, SZ_WORD, 0, 32'h0, 32'h1234_5678);
    @(posedge clk);
    #1;
    acc1 = cyc;
    wq.push_back('{addr: 32'h0, data: 32'h1234_5678, cyc: acc1});
    drive(1, 0, SZ_BYTE, 0, 32'h1, 32'h0);
    @(posedge clk);
    #1;
    chk("b2b idle gap", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    acc2 = cyc;
    req_valid_i = 1'b0;
    chk("b2b accepted", {31'd0, stall_o}, 32'd1);
    lq.push_back('{data: 32'h0000_0056, cyc: acc2 + 1});
    wait_idle(busy, rd1, en1);
    chk("b2b load busy", busy, 2);

    repeat (4) @(negedge clk);
    chk("writes drained", 32'(wq.size()), 32'd0);
    chk("loads drained", 32'(lq.size()), 32'd0);
    chk("errs drained", 32'(eq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory load/store interface in the pipelined CPU's MEM stage.
- Accepts one load/store request from the EX/MEM register and drives the word-wide, byte-addressed, little-endian data memory: combinational read, write on posedge.
- Supports byte, halfword and word accesses; sub-word stores use a read-modify-write sequence.
- Stalls the pipeline while busy and returns sign- or zero-extended load data.

Parameters:
- ADDR_LIMIT, 128, number of valid memory bytes; any byte address >= ADDR_LIMIT is an error.
- DATA_W, 32, data word width; fixed at 32, not otherwise supported.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request present; sampled only in IDLE
- req_load_i  in  1  request is a load
- req_store_i  in  1  request is a store
- req_size_i  in  2  access size: 00 byte, 01 halfword, 10 word; 11 illegal
- req_signed_i  in  1  sign-extend load result (1) or zero-extend (0)
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-justified
- stall_o  out  1  unit busy; upstream holds its request
- load_valid_o  out  1  one-cycle pulse: load_data_o valid
- load_data_o  out  32  extended load result
- err_o  out  1  one-cycle pulse: misaligned, out-of-range or illegal request
- mem_addr_o  out  32  word-aligned address to memory: {addr[31:2],2'b00}
- mem_data_o  out  32  write data to memory
- mem_read_o  out  1  memory read enable
- mem_write_o  out  1  memory write enable
- mem_data_i  in  32  memory read data (combinational from mem_addr_o)

Behaviour:
- Reset: all outputs 0; state IDLE; internal request registers cleared.
- Reset asserted mid-operation aborts immediately. No write is issued after reset; no pulse is emitted.
- States: IDLE, RD, WR, DONE.
- stall_o = (state != IDLE). It is derived from registered state only.
- IDLE, req_valid_i=1: latch addr, size, signed, wdata, and load/store type.
- Error check in IDLE:
  - error if load==store;
  - error if size==11;
  - error if halfword and addr[0]==1;
  - error if word and addr[1:0]!=0;
  - error if addr+bytes > ADDR_LIMIT.
- On error: err_o pulses the next cycle, no memory enable is asserted, and the unit stays in IDLE (no stall).
- Load: IDLE -> RD. In RD, mem_read_o=1 and mem_addr_o=aligned address; capture mem_data_i at the end of RD. Then -> DONE.
- In DONE:
  - load_valid_o=1 for exactly one cycle.
  - Byte: lane = addr[1:0], i.e. bits [8*lane+7 : 8*lane].
  - Halfword: lane = addr[1], i.e. bits [16*lane+15 : 16*lane].
  - Extend per req_signed_i. Then -> IDLE.
- load_data_o holds its value until the next load completes.
- Word store: IDLE -> WR. In WR, mem_write_o=1 and mem_data_o=wdata. -> IDLE.
- Sub-word store: IDLE -> RD (capture old word) -> WR. In WR, mem_data_o = old word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. -> IDLE.
- Latency from request acceptance edge:
  - load: 3 cycles to load_valid_o;
  - word store: 1 busy cycle;
  - sub-word store: 2 busy cycles.
- mem_read_o and mem_write_o are never both 1. Outside RD and WR both are 0, and mem_addr_o and mem_data_o hold their last value.
- A new request is accepted in the first IDLE cycle after completion (back-to-back allowed).

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state encodings;
  - ADDR_LIMIT default.
- One natural sub-module: mem_lane_align. It is combinational and does the lane extract/extend for loads and the lane merge for stores.
- The FSM and registers stay in mem_access_unit.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10, then word load @0x10. Required: one WR cycle with mem_data_o=0xDEADBEEF; load_valid_o with load_data_o=0xDEADBEEF 3 cycles after acceptance.
- Byte RMW: memory word @0x20 = 0x11223344; store byte 0xAA @0x22. Required: RD then WR with mem_data_o=0x11AA3344; stall_o high exactly 2 cycles.
- Signed/unsigned loads from word 0x80FF7F01 @0x30:
  - byte signed @0x32 -> 0xFFFFFFFF;
  - byte unsigned @0x33 -> 0x00000080;
  - half signed @0x32 -> 0xFFFF80FF.
- Errors produce err_o pulse, no mem_read_o/mem_write_o, stall_o stays 0:
  - half load @0x05;
  - word store @0x7E;
  - word load @0x80 (ADDR_LIMIT=128);
  - load and store both set.
- Reset mid-op: assert rst_i low during RD of a sub-word store. Required: all outputs 0 immediately; no mem_write_o after release; the next request completes normally.
- Back-to-back: word store @0x0 followed at once by a byte load @0x1. Required: second request accepted in the first IDLE cycle and returns the stored byte.
